// File: rtl/rr_mask_arb_pkg.sv
// Shared types for the round-robin mask arbiter.
// Index width helper and FSM state encoding.
package rr_mask_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic int idx_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rr_mask_sel.sv
// Thermometer-mask round-robin selector.
// Picks first request beyond ptr, else first overall.
module rr_mask_sel
  import rr_mask_arb_pkg::*;
#(
  parameter  int W           = 4,
  parameter  bit TOWARDS_LSB = 1'b1,
  localparam int IDX_W       = idx_w(W)
) (
  input  logic [W-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] excl_idx,
  input  logic             excl_en,
  output logic [W-1:0]     win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [W-1:0] req_eff;
  logic [W-1:0] pmask;
  logic [W-1:0] hit;
  logic [W-1:0] cand;

  // drop excluded bit, build mask of bits past ptr
  always_comb begin
    req_eff = req;
    pmask   = '0;
    for (int i = 0; i < W; i++) begin
      if (excl_en && (excl_idx == IDX_W'(i)))
        req_eff[i] = 1'b0;
      if (TOWARDS_LSB)
        pmask[i] = IDX_W'(i) > ptr;
      else
        pmask[i] = IDX_W'(i) < ptr;
    end
  end

  assign hit  = req_eff & pmask;
  assign cand = (|hit) ? hit : req_eff;
  assign any  = |req_eff;

  // first set bit in rotate direction; last write wins
  always_comb begin
    win     = '0;
    win_idx = '0;
    if (TOWARDS_LSB) begin
      for (int k = W - 1; k >= 0; k--) begin
        if (cand[k]) begin
          win     = '0;
          win[k]  = 1'b1;
          win_idx = IDX_W'(k);
        end
      end
    end else begin
      for (int k = 0; k < W; k++) begin
        if (cand[k]) begin
          win     = '0;
          win[k]  = 1'b1;
          win_idx = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/rr_mask_arb.sv
// Round-robin arbiter with registered grant,
// accept handshake, rotating pointer and lock.
module rr_mask_arb
  import rr_mask_arb_pkg::*;
#(
  parameter  int W           = 4,
  parameter  bit LOCK_EN     = 1'b0,
  parameter  bit TOWARDS_LSB = 1'b1,
  localparam int IDX_W       = idx_w(W)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [W-1:0]     i_req,
  input  logic             i_lock,
  input  logic             i_accept,
  output logic             o_gnt_vld,
  output logic [W-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  localparam logic [IDX_W-1:0] PTR_RST =
    TOWARDS_LSB ? IDX_W'(W - 1) : '0;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [W-1:0]     gnt_n;
  logic [IDX_W-1:0] idx_n;
  logic             vld_n;

  logic             take;
  logic             hold;
  logic [IDX_W-1:0] sel_ptr;
  logic [W-1:0]     win;
  logic [IDX_W-1:0] win_idx;
  logic             any;

  assign take    = (state == GRANT) && i_accept;
  assign hold    = LOCK_EN && i_lock && (|(i_req & o_gnt));
  assign sel_ptr = take ? o_gnt_idx : ptr;

  rr_mask_sel #(
    .W           (W),
    .TOWARDS_LSB (TOWARDS_LSB)
  ) u_sel (
    .req      (i_req),
    .ptr      (sel_ptr),
    .excl_idx (o_gnt_idx),
    .excl_en  (take),
    .win      (win),
    .win_idx  (win_idx),
    .any      (any)
  );

  // next state, pointer and grant
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = o_gnt;
    idx_n   = o_gnt_idx;
    vld_n   = o_gnt_vld;
    unique case (state)
      IDLE: begin
        if (any) begin
          gnt_n   = win;
          idx_n   = win_idx;
          vld_n   = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (i_accept && !hold) begin
          ptr_n = o_gnt_idx;
          if (any) begin
            gnt_n = win;
            idx_n = win_idx;
          end else begin
            gnt_n   = '0;
            idx_n   = '0;
            vld_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      ptr       <= PTR_RST;
      o_gnt     <= '0;
      o_gnt_idx <= '0;
      o_gnt_vld <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      o_gnt     <= gnt_n;
      o_gnt_idx <= idx_n;
      o_gnt_vld <= vld_n;
    end
  end

  // grant is one-hot when valid, zero otherwise
  always_comb begin
    if (arst_n)
      assert (o_gnt_vld ? $onehot(o_gnt) : (o_gnt == '0));
  end

  a_stable : assert property (
    @(posedge clk) disable iff (!arst_n)
    (o_gnt_vld && !i_accept) |=>
      ($stable(o_gnt) && $stable(o_gnt_idx))
  );

endmodule

// File: tb/tb_rr_mask_arb.sv
// Bench for rr_mask_arb: three configurations
// against a rotation-order reference model.
module tb_rr_mask_arb;

  logic       clk    = 1'b0;
  logic       arst_n = 1'b0;
  logic [3:0] req    = '0;
  logic       lock   = 1'b0;
  logic       acc    = 1'b0;

  logic       vld [3];
  logic [3:0] gnt [3];
  logic [1:0] idx [3];

  int n_chk = 0;
  int n_err = 0;

  bit m_vld [3];
  int m_idx [3];
  int m_ptr [3];

  always #5 clk = ~clk;

  rr_mask_arb #(
    .W(4), .LOCK_EN(1'b0), .TOWARDS_LSB(1'b1)
  ) u_a (
    .clk(clk), .arst_n(arst_n), .i_req(req),
    .i_lock(lock), .i_accept(acc),
    .o_gnt_vld(vld[0]), .o_gnt(gnt[0]),
    .o_gnt_idx(idx[0])
  );

  rr_mask_arb #(
    .W(4), .LOCK_EN(1'b1), .TOWARDS_LSB(1'b1)
  ) u_l (
    .clk(clk), .arst_n(arst_n), .i_req(req),
    .i_lock(lock), .i_accept(acc),
    .o_gnt_vld(vld[1]), .o_gnt(gnt[1]),
    .o_gnt_idx(idx[1])
  );

  rr_mask_arb #(
    .W(4), .LOCK_EN(1'b0), .TOWARDS_LSB(1'b0)
  ) u_d (
    .clk(clk), .arst_n(arst_n), .i_req(req),
    .i_lock(lock), .i_accept(acc),
    .o_gnt_vld(vld[2]), .o_gnt(gnt[2]),
    .o_gnt_idx(idx[2])
  );

  function automatic bit up(input int k);
    return k != 2;
  endfunction

  function automatic bit lk(input int k);
    return k == 1;
  endfunction

  // walk the ring from p in the rotate direction
  function automatic int pick(
    input logic [3:0] r, input int p, input bit u);
    for (int s = 1; s <= 4; s++) begin
      int i;
      i = u ? (p + s) % 4 : (p - s + 4) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_vld[k] = 1'b0;
      m_idx[k] = 0;
      m_ptr[k] = up(k) ? 3 : 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int g;
      if (!m_vld[k]) begin
        g = pick(req, m_ptr[k], up(k));
        if (g >= 0) begin
          m_vld[k] = 1'b1;
          m_idx[k] = g;
        end
      end else if (acc && !(lk(k) && lock
                   && req[m_idx[k]])) begin
        m_ptr[k] = m_idx[k];
        g = pick(req & ~(4'b1 << m_idx[k]),
                 m_idx[k], up(k));
        if (g >= 0) begin
          m_idx[k] = g;
        end else begin
          m_vld[k] = 1'b0;
          m_idx[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string ph);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] eg;
      eg = m_vld[k] ? (4'b1 << m_idx[k]) : 4'b0;
      chk($sformatf("%s_d%0d_vld", ph, k),
          32'(vld[k]), 32'(m_vld[k]));
      chk($sformatf("%s_d%0d_gnt", ph, k),
          32'(gnt[k]), 32'(eg));
      chk($sformatf("%s_d%0d_idx", ph, k),
          32'(idx[k]), 32'(m_idx[k]));
    end
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_step();
    #1;
    compare_all(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    req    = '0;
    acc    = 1'b0;
    lock   = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  int seq_a [6] = '{0, 1, 2, 3, 0, 1};
  int seq_d [6] = '{3, 2, 1, 0, 3, 2};

  initial begin
    model_reset();

    // rotation with a sparse request
    do_reset();
    req = 4'b1010;
    cycle("t1a");
    chk("t1_gnt", 32'(gnt[0]), 32'h2);
    chk("t1_idx", 32'(idx[0]), 32'd1);
    acc = 1'b1;
    cycle("t1b");
    chk("t1_gnt2", 32'(gnt[0]), 32'h8);
    cycle("t1c");
    chk("t1_wrap", 32'(idx[0]), 32'd1);
    acc = 1'b0;

    // back-to-back grants, both directions
    do_reset();
    req = 4'b1111;
    acc = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle("b2b");
      chk($sformatf("b2b_up%0d", c),
          32'(idx[0]), 32'(seq_a[c]));
      chk($sformatf("b2b_vld%0d", c),
          32'(vld[0]), 32'd1);
      chk($sformatf("b2b_dn%0d", c),
          32'(idx[2]), 32'(seq_d[c]));
    end
    acc = 1'b0;

    // sticky grant while requests change
    do_reset();
    req = 4'b0100;
    cycle("st0");
    req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      cycle("st1");
      chk($sformatf("sticky%0d", c),
          32'(gnt[0]), 32'h4);
    end
    acc = 1'b1;
    cycle("st2");
    chk("st_next", 32'(gnt[0]), 32'h1);
    req = 4'b0000;
    cycle("st3");
    chk("st_idle", 32'(vld[0]), 32'd0);
    acc = 1'b0;
    cycle("st4");

    // lock holds the grant across accepts
    do_reset();
    req = 4'b0010;
    cycle("lk0");
    req  = 4'b0011;
    lock = 1'b1;
    acc  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle("lk1");
      chk($sformatf("lock%0d", c),
          32'(idx[1]), 32'd1);
    end
    lock = 1'b0;
    cycle("lk2");
    chk("unlock", 32'(idx[1]), 32'd0);
    acc = 1'b0;

    // async reset mid-grant
    do_reset();
    req = 4'b0100;
    cycle("ar0");
    chk("ar_pre", 32'(idx[0]), 32'd2);
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_vld", 32'(vld[0]), 32'd0);
    chk("ar_gnt", 32'(gnt[0]), 32'd0);
    compare_all("ar1");
    @(negedge clk);
    req    = 4'b1111;
    arst_n = 1'b1;
    cycle("ar2");
    chk("ar_first", 32'(idx[0]), 32'd0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req  = 4'($urandom);
      acc  = ($urandom_range(0, 9) < 7);
      lock = 1'($urandom);
      cycle("rnd");
      if ($urandom_range(0, 99) == 0)
        do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
